// File: rtl/morse_char_sequencer.sv
// Morse symbol-group assembler with output FIFO and four-character display history.
// Define MORSE_DIGITS_EN to decode the ten 5-symbol digit patterns to 26..35.
module morse_char_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       sym_en,
    input  logic [1:0] sym,
    output logic       out_valid,
    output logic [5:0] out_code,
    input  logic       out_ready,
    output logic [5:0] disp0,
    output logic [5:0] disp1,
    output logic [5:0] disp2,
    output logic [5:0] disp3,
    output logic [2:0] sym_count,
    output logic       busy,
    output logic       ovf,
    output logic       drop
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [5:0] CODE_ERR   = 6'h3F;
    localparam logic [5:0] CODE_BLANK = 6'h3E;

    typedef enum logic [1:0] {IDLE, COLLECT, LOOKUP, PUSH} state_t;

    state_t      state_reg;
    logic [4:0]  pat_reg;
    logic [2:0]  len_reg;
    logic        too_long_reg;
    logic [5:0]  code_reg;
    logic [5:0]  hist_reg [4];

    logic [5:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_reg, wr_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, remain_next, count_next;
    logic          pop, push, fifo_full, is_mark;

    // pat holds the first symbol in bit 0; the table is written first-symbol-MSB,
    // so reverse and right-justify before matching.
    function automatic logic [5:0] decode(input logic [2:0] len, input logic [4:0] pat);
        logic [4:0] rev;
        logic [4:0] seq;
        logic [5:0] c;
        for (int i = 0; i < 5; i++) rev[4-i] = pat[i];
        seq = rev >> (3'd5 - len);
        case ({len, seq})
            {3'd2, 5'b00001}: c = 6'd0;   // A
            {3'd4, 5'b01000}: c = 6'd1;   // B
            {3'd4, 5'b01010}: c = 6'd2;   // C
            {3'd3, 5'b00100}: c = 6'd3;   // D
            {3'd1, 5'b00000}: c = 6'd4;   // E
            {3'd4, 5'b00010}: c = 6'd5;   // F
            {3'd3, 5'b00110}: c = 6'd6;   // G
            {3'd4, 5'b00000}: c = 6'd7;   // H
            {3'd2, 5'b00000}: c = 6'd8;   // I
            {3'd4, 5'b00111}: c = 6'd9;   // J
            {3'd3, 5'b00101}: c = 6'd10;  // K
            {3'd4, 5'b00100}: c = 6'd11;  // L
            {3'd2, 5'b00011}: c = 6'd12;  // M
            {3'd2, 5'b00010}: c = 6'd13;  // N
            {3'd3, 5'b00111}: c = 6'd14;  // O
            {3'd4, 5'b00110}: c = 6'd15;  // P
            {3'd4, 5'b01101}: c = 6'd16;  // Q
            {3'd3, 5'b00010}: c = 6'd17;  // R
            {3'd3, 5'b00000}: c = 6'd18;  // S
            {3'd1, 5'b00001}: c = 6'd19;  // T
            {3'd3, 5'b00001}: c = 6'd20;  // U
            {3'd4, 5'b00001}: c = 6'd21;  // V
            {3'd3, 5'b00011}: c = 6'd22;  // W
            {3'd4, 5'b01001}: c = 6'd23;  // X
            {3'd4, 5'b01011}: c = 6'd24;  // Y
            {3'd4, 5'b01100}: c = 6'd25;  // Z
`ifdef MORSE_DIGITS_EN
            {3'd5, 5'b11111}: c = 6'd26;
            {3'd5, 5'b01111}: c = 6'd27;
            {3'd5, 5'b00111}: c = 6'd28;
            {3'd5, 5'b00011}: c = 6'd29;
            {3'd5, 5'b00001}: c = 6'd30;
            {3'd5, 5'b00000}: c = 6'd31;
            {3'd5, 5'b10000}: c = 6'd32;
            {3'd5, 5'b11000}: c = 6'd33;
            {3'd5, 5'b11100}: c = 6'd34;
            {3'd5, 5'b11110}: c = 6'd35;
`endif
            default:          c = CODE_ERR;
        endcase
        return c;
    endfunction

    assign is_mark   = (sym == 2'b01) || (sym == 2'b10);
    assign pop       = out_valid && out_ready;
    assign fifo_full = (count_reg == CW'(FIFO_DEPTH));
    assign push      = (state_reg == PUSH) && (!fifo_full || pop) && !clr;

    always_comb begin
        rd_ptr_next = rd_ptr_reg + PW'(pop);
        remain_next = count_reg - CW'(pop);
        count_next  = remain_next + CW'(push);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            pat_reg      <= '0;
            len_reg      <= '0;
            too_long_reg <= 1'b0;
            code_reg     <= '0;
            busy         <= 1'b0;
            ovf          <= 1'b0;
            drop         <= 1'b0;
            for (int i = 0; i < 4; i++) hist_reg[i] <= CODE_BLANK;
        end else if (clr) begin
            state_reg    <= IDLE;
            pat_reg      <= '0;
            len_reg      <= '0;
            too_long_reg <= 1'b0;
            code_reg     <= '0;
            busy         <= 1'b0;
            ovf          <= 1'b0;
            drop         <= 1'b0;
            for (int i = 0; i < 4; i++) hist_reg[i] <= CODE_BLANK;
        end else begin
            case (state_reg)
                IDLE: if (sym_en && is_mark) begin
                    pat_reg[0] <= (sym == 2'b10);
                    len_reg    <= 3'd1;
                    state_reg  <= COLLECT;
                    busy       <= 1'b1;
                end
                COLLECT: if (sym_en) begin
                    if (is_mark) begin
                        if (len_reg < 3'd5) begin
                            pat_reg[len_reg] <= (sym == 2'b10);
                            len_reg          <= len_reg + 3'd1;
                        end else begin
                            too_long_reg <= 1'b1;
                        end
                    end else if (sym == 2'b00) begin
                        state_reg <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    code_reg  <= too_long_reg ? CODE_ERR : decode(len_reg, pat_reg);
                    state_reg <= PUSH;
                    if (sym_en) drop <= 1'b1;
                end
                PUSH: begin
                    if (fifo_full && !pop) ovf <= 1'b1;
                    if (sym_en) drop <= 1'b1;
                    hist_reg[0]  <= code_reg;
                    for (int i = 1; i < 4; i++) hist_reg[i] <= hist_reg[i-1];
                    pat_reg      <= '0;
                    len_reg      <= '0;
                    too_long_reg <= 1'b0;
                    state_reg    <= IDLE;
                    busy         <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign sym_count = len_reg;
    assign disp0 = hist_reg[0];
    assign disp1 = hist_reg[1];
    assign disp2 = hist_reg[2];
    assign disp3 = hist_reg[3];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= code_reg;
    end

    // out_code tracks the head after this edge; a push into an otherwise
    // empty FIFO bypasses the array so it is visible one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            out_valid  <= 1'b0;
            out_code   <= '0;
        end else if (clr) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            out_valid  <= 1'b0;
            out_code   <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            out_valid  <= (count_next != '0);
            if (remain_next != '0)
                out_code <= mem[rd_ptr_next];
            else if (push)
                out_code <= code_reg;
        end
    end
endmodule

// File: tb/tb_morse_char_sequencer.sv
// Directed self-checking bench for morse_char_sequencer (default FIFO_DEPTH = 4).
module tb_morse_char_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clr = 1'b0;
    logic       sym_en = 1'b0;
    logic [1:0] sym = 2'b00;
    logic       out_ready = 1'b0;
    logic       out_valid, busy, ovf, drop;
    logic [5:0] out_code, disp0, disp1, disp2, disp3;
    logic [2:0] sym_count;

    int n_checks = 0;
    int n_fail   = 0;

    morse_char_sequencer #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .clr(clr), .sym_en(sym_en), .sym(sym),
        .out_valid(out_valid), .out_code(out_code), .out_ready(out_ready),
        .disp0(disp0), .disp1(disp1), .disp2(disp2), .disp3(disp3),
        .sym_count(sym_count), .busy(busy), .ovf(ovf), .drop(drop)
    );

    always #5 clk = ~clk;

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Strobe is high for the cycle after the next negedge; returns one cycle later.
    task automatic strobe(input logic [1:0] s);
        @(negedge clk); sym_en = 1'b1; sym = s;
        @(negedge clk); sym_en = 1'b0; sym = 2'b00;
    endtask

    task automatic pulse_clr();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    task automatic send_e();
        strobe(2'b01); strobe(2'b00); idle(3);
    endtask

    task automatic pop_expect(input logic [5:0] exp, input string nm);
        n_checks++;
        if (out_valid !== 1'b1 || out_code !== exp) begin
            n_fail++;
            $display("FAIL %s: out_valid=%0b out_code=%0d, required 1/%0d", nm, out_valid, out_code, exp);
        end
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        $display("pop %s code=%0d", nm, exp);
    endtask

    task automatic test_reset();
        idle(3);
        reset = 1'b0;
        idle(1);
        n_checks++;
        if (out_valid !== 1'b0 || out_code !== 6'd0 || busy !== 1'b0 || sym_count !== 3'd0 ||
            ovf !== 1'b0 || drop !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: v=%0b code=%0d busy=%0b cnt=%0d ovf=%0b drop=%0b, required 0/0/0/0/0/0",
                     out_valid, out_code, busy, sym_count, ovf, drop);
        end
        n_checks++;
        if ({disp0, disp1, disp2, disp3} !== {4{6'h3E}}) begin
            n_fail++;
            $display("FAIL reset_disp: %h %h %h %h, required all 3e", disp0, disp1, disp2, disp3);
        end
        $display("test_reset done");
    endtask

    task automatic test_letter_a();
        out_ready = 1'b1;
        strobe(2'b01); idle(8);
        strobe(2'b10); idle(8);
        strobe(2'b00);
        idle(1);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL a_early: out_valid=%0b at T+2, required 0", out_valid);
        end
        idle(1);
        n_checks++;
        if (out_valid !== 1'b1 || out_code !== 6'd0) begin
            n_fail++; $display("FAIL a_t3: out_valid=%0b out_code=%0d, required 1/0", out_valid, out_code);
        end
        n_checks++;
        if (disp0 !== 6'd0 || disp1 !== 6'h3E || disp2 !== 6'h3E || disp3 !== 6'h3E) begin
            n_fail++; $display("FAIL a_disp: %h %h %h %h, required 00 3e 3e 3e", disp0, disp1, disp2, disp3);
        end
        idle(1);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL a_pulse: out_valid=%0b after pop, required 0", out_valid);
        end
        $display("char A code=%0d", out_code);
    endtask

    task automatic test_five_dashes();
        logic [5:0] exp;
`ifdef MORSE_DIGITS_EN
        exp = 6'd26;
`else
        exp = 6'h3F;
`endif
        repeat (5) strobe(2'b10);
        n_checks++;
        if (sym_count !== 3'd5 || busy !== 1'b1) begin
            n_fail++; $display("FAIL dash5_cnt: sym_count=%0d busy=%0b, required 5/1", sym_count, busy);
        end
        strobe(2'b00); idle(2);
        n_checks++;
        if (out_valid !== 1'b1 || out_code !== exp) begin
            n_fail++; $display("FAIL dash5_code: v=%0b code=%0d, required 1/%0d", out_valid, out_code, exp);
        end
        n_checks++;
        if (sym_count !== 3'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL dash5_after: sym_count=%0d busy=%0b, required 0/0", sym_count, busy);
        end
        $display("char ----- code=%0d", out_code);
        idle(2);
    endtask

    task automatic test_too_long();
        repeat (6) strobe(2'b01);
        n_checks++;
        if (sym_count !== 3'd5) begin
            n_fail++; $display("FAIL long_cnt: sym_count=%0d, required 5", sym_count);
        end
        strobe(2'b00); idle(2);
        n_checks++;
        if (out_valid !== 1'b1 || out_code !== 6'h3F) begin
            n_fail++; $display("FAIL long_code: v=%0b code=%0d, required 1/63", out_valid, out_code);
        end
        $display("char ...... code=%0d", out_code);
        idle(2);
    endtask

    task automatic test_back_to_back();
        @(negedge clk); sym_en = 1'b1; sym = 2'b10;
        @(negedge clk); sym = 2'b01;
        @(negedge clk); sym = 2'b00;
        @(negedge clk); sym_en = 1'b0;
        idle(2);
        n_checks++;
        if (out_valid !== 1'b1 || out_code !== 6'd13 || drop !== 1'b0) begin
            n_fail++; $display("FAIL b2b_n: v=%0b code=%0d drop=%0b, required 1/13/0", out_valid, out_code, drop);
        end
        $display("char N code=%0d", out_code);
        idle(2);
    endtask

    task automatic test_drop();
        strobe(2'b01); strobe(2'b00);
        sym_en = 1'b1; sym = 2'b01;    // lands in LOOKUP
        @(negedge clk); sym_en = 1'b0; sym = 2'b00;
        idle(1);
        n_checks++;
        if (out_code !== 6'd4 || drop !== 1'b1 || sym_count !== 3'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL drop_set: code=%0d drop=%0b cnt=%0d busy=%0b, required 4/1/0/0",
                               out_code, drop, sym_count, busy);
        end
        pulse_clr();
        n_checks++;
        if (drop !== 1'b0 || disp0 !== 6'h3E || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL drop_clr: drop=%0b disp0=%h v=%0b, required 0/3e/0", drop, disp0, out_valid);
        end
        $display("char E with drop code=4");
    endtask

    task automatic test_overflow();
        pulse_clr();
        out_ready = 1'b0;
        repeat (4) send_e();
        n_checks++;
        if (ovf !== 1'b0) begin
            n_fail++; $display("FAIL ovf_early: ovf=%0b after 4 chars, required 0", ovf);
        end
        send_e();
        n_checks++;
        if (ovf !== 1'b1 || {disp0, disp1, disp2, disp3} !== {4{6'd4}}) begin
            n_fail++; $display("FAIL ovf_set: ovf=%0b disp=%h %h %h %h, required 1 and all 04",
                               ovf, disp0, disp1, disp2, disp3);
        end
        pop_expect(6'd4, "ovf_pop0");
        pop_expect(6'd4, "ovf_pop1");
        pop_expect(6'd4, "ovf_pop2");
        pop_expect(6'd4, "ovf_pop3");
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL ovf_empty: out_valid=%0b, required 0", out_valid);
        end
    endtask

    task automatic test_full_push();
        pulse_clr();
        out_ready = 1'b0;
        repeat (4) send_e();
        strobe(2'b10); strobe(2'b00);
        idle(1); out_ready = 1'b1;     // PUSH cycle
        idle(1); out_ready = 1'b0;
        n_checks++;
        if (ovf !== 1'b0 || out_valid !== 1'b1 || out_code !== 6'd4) begin
            n_fail++; $display("FAIL full_push: ovf=%0b v=%0b code=%0d, required 0/1/4", ovf, out_valid, out_code);
        end
        pop_expect(6'd4, "full_pop0");
        pop_expect(6'd4, "full_pop1");
        pop_expect(6'd4, "full_pop2");
        pop_expect(6'd19, "full_pop3");
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL full_empty: out_valid=%0b, required 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        strobe(2'b01); strobe(2'b10);
        n_checks++;
        if (busy !== 1'b1 || sym_count !== 3'd2) begin
            n_fail++; $display("FAIL mid_busy: busy=%0b cnt=%0d, required 1/2", busy, sym_count);
        end
        reset = 1'b1; idle(2); reset = 1'b0;
        idle(1);
        n_checks++;
        if (busy !== 1'b0 || sym_count !== 3'd0 || out_valid !== 1'b0 ||
            {disp0, disp1, disp2, disp3} !== {4{6'h3E}}) begin
            n_fail++; $display("FAIL mid_reset: busy=%0b cnt=%0d v=%0b disp=%h %h %h %h, required 0/0/0/3e",
                               busy, sym_count, out_valid, disp0, disp1, disp2, disp3);
        end
        strobe(2'b01); strobe(2'b00);
        idle(2);
        n_checks++;
        if (out_valid !== 1'b1 || out_code !== 6'd4) begin
            n_fail++; $display("FAIL mid_next: v=%0b code=%0d, required 1/4", out_valid, out_code);
        end
        $display("char E after reset code=%0d", out_code);
    endtask

    initial begin
        test_reset();
        test_letter_a();
        test_five_dashes();
        test_too_long();
        test_back_to_back();
        test_drop();
        test_overflow();
        test_full_push();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/morse_char_sequencer.md
# morse_char_sequencer

Collects the dot/dash/space symbol stream from the push-button Morse input converter and assembles each symbol group into a character code. Completed characters are queued in a small output FIFO for the downstream consumer, and a four-character history is kept for the seven-segment display. The block sits between the input converter and the display/consumer logic on the 100 MHz Basys 3 clock domain.

## Interface
- FIFO_DEPTH, 4: output FIFO entries; power of two, 2..16
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-high
- clr  in  1  synchronous clear: pattern, FIFO, history and flags
- sym_en  in  1  one-cycle symbol strobe from the converter
- sym  in  2  01 dot, 10 dash, 00 space, 11 ignored
- out_valid  out  1  FIFO not empty
- out_code  out  6  FIFO head; 0..25 = A..Z, 26..35 = 0..9, 0x3F = error
- out_ready  in  1  consumer pops the head when out_valid && out_ready
- disp0..disp3  out  6 each  last four characters, disp0 newest; 0x3E = blank
- sym_count  out  3  symbols held in the current pattern (0..5)
- busy  out  1  high in every state except IDLE
- ovf  out  1  sticky: a character was lost because the FIFO was full
- drop  out  1  sticky: sym_en arrived in LOOKUP or PUSH

## Operation
- Pattern register pat[4:0] and len[2:0]. The symbol with index len is written to pat[len]; dash = 1, dot = 0. Example: A (.-) gives len = 2, pat[1:0] = 2'b10.
- States and transitions:
  - IDLE: a dot or dash stores the symbol and moves to COLLECT. Space and 11 are ignored.
  - COLLECT: a dot or dash is appended while len < 5. At len = 5, a further dot or dash sets too_long and is not stored. Space moves to LOOKUP.
  - LOOKUP: lasts one cycle. Registers the decoded code: too_long, or a pattern with no assigned character, gives 0x3F. Moves to PUSH.
  - PUSH: lasts one cycle.
    - Writes the code to the FIFO if not full, or if a pop occurs in the same cycle.
    - Otherwise discards the code and sets ovf.
    - Always shifts the code into the history: disp3 <= disp2 <= disp1 <= disp0 <= code.
    - Clears pat, len and too_long, then returns to IDLE.
- sym_en in LOOKUP or PUSH: the symbol is discarded and drop is set.
- Lookup table: standard international Morse for A..Z (1–4 symbols). All other patterns give 0x3F, except 5-symbol digit patterns when the configuration macro enables them.
- FIFO:
  - Pop and push in the same cycle leave the count unchanged.
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- clr takes priority over all state activity. It returns the FSM to IDLE, empties the FIFO, sets disp0..3 to 0x3E and clears ovf and drop.
- Reset values:
  - state IDLE; out_valid 0; out_code 0; disp0..3 0x3E; sym_count 0; busy 0; ovf 0; drop 0.
  - FIFO empty.
  - Reset mid-pattern discards the pattern; no character is emitted.

## Timing
- Fully synchronous to clk; reset is the only asynchronous input.
- Space strobe at cycle T: LOOKUP at T+1, PUSH at T+2. With an empty FIFO, out_valid is high and out_code valid at T+3, and disp0 is updated at T+3.
- out_code is registered from the FIFO head. After a pop at cycle P, the next entry, or out_valid = 0, is visible at P+1.
- sym_count and busy are registered and reflect the state after each edge.
- The converter cannot issue back-to-back strobes. Even so, the block must accept a strobe on every cycle in IDLE and COLLECT.

## Configuration
- MORSE_DIGITS_EN defined: the ten 5-symbol digit patterns decode to 26..35 (----- = 26 for '0', .---- = 27 for '1', ..., ----. = 35 for '9').
- MORSE_DIGITS_EN undefined: every 5-symbol pattern decodes to 0x3F. The digit table is not synthesized.

## Test plan
- Dot, dash, space strobes 10 cycles apart, out_ready = 1 -> out_valid pulses with out_code = 0 (A) exactly 3 cycles after the space strobe; disp0 = 0, disp1..3 = 0x3E.
- Five dashes, then space -> out_code = 26 with MORSE_DIGITS_EN, 0x3F without it; sym_count reads 5 before the space and 0 after.
- Six dots, then space -> out_code = 0x3F; the sixth symbol is not counted (sym_count stays 5).
- out_ready = 0; five single-dot characters (E = 4) -> four FIFO entries of 4, ovf = 1, disp0..3 all 4; popping four times empties the FIFO.
- FIFO full with out_ready = 1 in the PUSH cycle -> push succeeds, count stays FIFO_DEPTH, ovf stays 0.
- Reset asserted after dot, dash (busy = 1) -> busy 0, sym_count 0, out_valid 0, disp0..3 0x3E; next dot, space gives out_code = 4 (E).
